// File: rtl/reset_sequencer.sv
// Reset sequencer: releases NUM_STAGES downstream reset domains one at a
// time, in index order. Each release comes after DELAY hold cycles and must
// be acknowledged by that domain within TIMEOUT cycles. A missing ack parks
// the sequencer in ERROR, with the offending stage held in reset again.
module reset_sequencer #(
  parameter int NUM_STAGES = 3,
  parameter int DELAY      = 4,
  parameter int TIMEOUT    = 16,
  parameter int IDX_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  sw_rst_req,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_rst_o,
  output logic                  all_ready,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [IDX_W-1:0]      fail_stage
);

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam logic [7:0]       DELAY_LAST   = 8'(DELAY - 1);
  localparam logic [7:0]       TIMEOUT_LAST = 8'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_STAGES - 1);

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic [7:0]              cnt, cnt_nxt;
  logic [NUM_STAGES-1:0]   stage_rst_nxt;
  logic                    all_ready_nxt;
  logic                    busy_nxt;
  logic                    timeout_err_nxt;
  logic [IDX_W-1:0]        fail_stage_nxt;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    cnt_nxt         = cnt;
    stage_rst_nxt   = stage_rst_o;
    all_ready_nxt   = all_ready;
    busy_nxt        = busy;
    timeout_err_nxt = timeout_err;
    fail_stage_nxt  = fail_stage;

    if (sw_rst_req) begin
      // Software restart: same landing values as a hardware reset.
      state_nxt       = HOLD;
      idx_nxt         = '0;
      cnt_nxt         = '0;
      stage_rst_nxt   = '1;
      all_ready_nxt   = 1'b0;
      busy_nxt        = 1'b1;
      timeout_err_nxt = 1'b0;
      fail_stage_nxt  = '0;
    end else begin
      unique case (state)
        HOLD: begin
          if (cnt == DELAY_LAST) begin
            stage_rst_nxt[idx] = 1'b0;
            cnt_nxt            = '0;
            state_nxt          = WAIT;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
        WAIT: begin
          // Only the stage just released is looked at; other acks are noise.
          if (stage_ack[idx]) begin
            if (idx == LAST_IDX) begin
              state_nxt     = DONE;
              all_ready_nxt = 1'b1;
              busy_nxt      = 1'b0;
            end else begin
              idx_nxt   = idx + 1'b1;
              cnt_nxt   = '0;
              state_nxt = HOLD;
            end
          end else if (cnt == TIMEOUT_LAST) begin
            // Put the silent stage back into reset; earlier stages stay up.
            state_nxt          = ERROR;
            timeout_err_nxt    = 1'b1;
            fail_stage_nxt     = idx;
            busy_nxt           = 1'b0;
            stage_rst_nxt[idx] = 1'b1;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
        DONE: begin
          // Ready tracks the live acks without re-running the sequence.
          all_ready_nxt = &stage_ack;
        end
        ERROR: begin
          // Parked until a hardware or software reset.
        end
        default: begin
          state_nxt = HOLD;
        end
      endcase
    end
  end

  // State and output registers; rst_i overrides everything, including sw_rst_req.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state       <= HOLD;
      idx         <= '0;
      cnt         <= '0;
      stage_rst_o <= '1;
      all_ready   <= 1'b0;
      busy        <= 1'b1;
      timeout_err <= 1'b0;
      fail_stage  <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      cnt         <= cnt_nxt;
      stage_rst_o <= stage_rst_nxt;
      all_ready   <= all_ready_nxt;
      busy        <= busy_nxt;
      timeout_err <= timeout_err_nxt;
      fail_stage  <= fail_stage_nxt;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a timeline model of the release schedule
// checked against the DUT on every cycle, plus literal spot checks.
module tb_reset_sequencer;

  localparam int NS = 3;
  localparam int DL = 4;
  localparam int TO = 16;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          sw_rst_req = 1'b0;
  logic [NS-1:0] stage_ack = '1;
  logic [NS-1:0] stage_rst_o;
  logic          all_ready;
  logic          busy;
  logic          timeout_err;
  logic [IW-1:0] fail_stage;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_STAGES(NS),
    .DELAY     (DL),
    .TIMEOUT   (TO),
    .IDX_W     (IW)
  ) dut (
    .clk        (clk),
    .rst_i      (rst_i),
    .sw_rst_req (sw_rst_req),
    .stage_ack  (stage_ack),
    .stage_rst_o(stage_rst_o),
    .all_ready  (all_ready),
    .busy       (busy),
    .timeout_err(timeout_err),
    .fail_stage (fail_stage)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Timeline model: m_rel stages released so far; m_start is the edge at which
  // the current hold (or wait) period began; deadlines are plain edge distances.
  int m_t = 0;
  int m_start = 0;
  int m_rel = 0;
  int m_fail = 0;
  bit m_wait = 0, m_done = 0, m_err = 0, m_ready = 0, m_valid = 0;

  always @(posedge clk) begin
    m_t++;
    if (rst_i || sw_rst_req) begin
      m_valid = 1; m_rel = 0; m_wait = 0; m_done = 0;
      m_err = 0; m_ready = 0; m_fail = 0; m_start = m_t;
    end else if (!m_valid || m_err) begin
      // nothing moves
    end else if (m_done) begin
      m_ready = &stage_ack;
    end else if (!m_wait) begin
      if (m_t - m_start == DL) begin
        m_rel++; m_wait = 1; m_start = m_t;
      end
    end else if (stage_ack[m_rel-1]) begin
      if (m_rel == NS) begin
        m_done = 1; m_ready = 1;
      end else begin
        m_wait = 0; m_start = m_t;
      end
    end else if (m_t - m_start == TO) begin
      m_err = 1; m_fail = m_rel - 1; m_rel--;
    end
  end

  function automatic logic [NS-1:0] exp_rst();
    logic [NS-1:0] mask;
    mask = '0;
    for (int i = 0; i < NS; i++) mask[i] = (i >= m_rel);
    return mask;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_stage_rst_o", 32'(stage_rst_o), 32'(exp_rst()));
      chk("m_all_ready",   32'(all_ready),   32'(m_ready));
      chk("m_busy",        32'(busy),        32'(!(m_done || m_err)));
      chk("m_timeout_err", 32'(timeout_err), 32'(m_err));
      chk("m_fail_stage",  32'(fail_stage),  32'(m_fail));
    end
  end

  task automatic go(input int target);
    while (edge_n < target) begin
      @(posedge clk);
      #1;
      edge_n++;
    end
  endtask

  initial begin
    // Power-on reset, acks tied high
    edge_n = 0; go(2);
    chk("rst_stage_rst", 32'(stage_rst_o), 32'h7);
    chk("rst_busy",      32'(busy),        32'h1);
    chk("rst_all_ready", 32'(all_ready),   32'h0);
    chk("rst_terr",      32'(timeout_err), 32'h0);
    chk("rst_fail",      32'(fail_stage),  32'h0);
    rst_i = 1'b0; edge_n = 0;
    go(3);  chk("seq_e3",  32'(stage_rst_o), 32'h7);
    go(4);  chk("seq_e4",  32'(stage_rst_o), 32'h6);
    go(8);  chk("seq_e8",  32'(stage_rst_o), 32'h6);
    go(9);  chk("seq_e9",  32'(stage_rst_o), 32'h4);
    go(14); chk("seq_e14", 32'(stage_rst_o), 32'h0);
            chk("seq_e14_rdy", 32'(all_ready), 32'h0);
    go(15); chk("seq_e15_rdy", 32'(all_ready), 32'h1);
            chk("seq_e15_busy", 32'(busy), 32'h0);

    // Drop an ack while DONE
    go(17); stage_ack = 3'b011;
    go(18); chk("drop_rdy",  32'(all_ready),   32'h0);
            chk("drop_rst",  32'(stage_rst_o), 32'h0);
            chk("drop_busy", 32'(busy),        32'h0);
    stage_ack = 3'b111;
    go(19); chk("restore_rdy", 32'(all_ready), 32'h1);

    // Stage 1 never acks -> timeout
    rst_i = 1'b1; stage_ack = 3'b101; edge_n = 0; go(2);
    rst_i = 1'b0; edge_n = 0;
    go(9);  chk("to_e9",   32'(stage_rst_o), 32'h4);
    go(24); chk("to_e24",  32'(timeout_err), 32'h0);
    go(25); chk("to_e25_rst",  32'(stage_rst_o), 32'h6);
            chk("to_e25_terr", 32'(timeout_err), 32'h1);
            chk("to_e25_fail", 32'(fail_stage),  32'h1);
            chk("to_e25_busy", 32'(busy),        32'h0);
    go(45); chk("to_hold_rst",  32'(stage_rst_o), 32'h6);
            chk("to_hold_terr", 32'(timeout_err), 32'h1);

    // Software restart out of ERROR
    stage_ack = 3'b111; sw_rst_req = 1'b1; edge_n = 0; go(1);
    chk("sw_rst",  32'(stage_rst_o), 32'h7);
    chk("sw_terr", 32'(timeout_err), 32'h0);
    chk("sw_busy", 32'(busy),        32'h1);
    sw_rst_req = 1'b0; edge_n = 0;
    go(3);  chk("sw_e3",  32'(stage_rst_o), 32'h7);
    go(4);  chk("sw_e4",  32'(stage_rst_o), 32'h6);
    go(9);  chk("sw_e9",  32'(stage_rst_o), 32'h4);
    go(14); chk("sw_e14", 32'(stage_rst_o), 32'h0);
    go(15); chk("sw_e15_rdy", 32'(all_ready), 32'h1);

    // rst_i in WAIT of stage 1, then early acks on stages 1 and 2
    rst_i = 1'b1; stage_ack = 3'b001; edge_n = 0; go(2);
    rst_i = 1'b0; edge_n = 0;
    go(9);  chk("mid_e9", 32'(stage_rst_o), 32'h4);
    rst_i = 1'b1; stage_ack = 3'b111;
    go(10); chk("mid_e10_rst",  32'(stage_rst_o), 32'h7);
            chk("mid_e10_rdy",  32'(all_ready),   32'h0);
            chk("mid_e10_busy", 32'(busy),        32'h1);
    rst_i = 1'b0; edge_n = 0;
    go(4);  chk("early_e4",  32'(stage_rst_o), 32'h6);
    go(8);  chk("early_e8",  32'(stage_rst_o), 32'h6);
    go(9);  chk("early_e9",  32'(stage_rst_o), 32'h4);
    go(13); chk("early_e13", 32'(stage_rst_o), 32'h4);
    go(14); chk("early_e14", 32'(stage_rst_o), 32'h0);
    go(15); chk("early_e15", 32'(all_ready),   32'h1);

    // rst_i and sw_rst_req together during HOLD
    rst_i = 1'b1; edge_n = 0; go(1);
    rst_i = 1'b0; edge_n = 0; go(2);
    rst_i = 1'b1; sw_rst_req = 1'b1;
    go(3);  chk("both_rst",  32'(stage_rst_o), 32'h7);
            chk("both_busy", 32'(busy),        32'h1);
    rst_i = 1'b0; sw_rst_req = 1'b0; edge_n = 0;
    go(3);  chk("both_e3", 32'(stage_rst_o), 32'h7);
    go(4);  chk("both_e4", 32'(stage_rst_o), 32'h6);
    go(15); chk("both_e15", 32'(all_ready),  32'h1);

    // Software restart from DONE
    sw_rst_req = 1'b1; edge_n = 0; go(1);
    chk("swd_rst", 32'(stage_rst_o), 32'h7);
    chk("swd_rdy", 32'(all_ready),   32'h0);
    sw_rst_req = 1'b0; edge_n = 0;
    go(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 3: number of downstream reset domains released in order, legal range 2..8.
REQ-002 Parameter DELAY, default 4: cycles all remaining resets are held before each release, legal range 2..255.
REQ-003 Parameter TIMEOUT, default 16: maximum cycles spent waiting for the current stage ack, legal range 2..255.
REQ-004 Parameter IDX_W, default 2: width of the stage index; SHALL satisfy 2^IDX_W >= NUM_STAGES.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_i  in  1  synchronous, active-high reset (the stretched system reset).
REQ-007 sw_rst_req  in  1  single-cycle software request to re-run the full sequence.
REQ-008 stage_ack  in  NUM_STAGES  bit i high = domain i reports ready after its reset is released.
REQ-009 stage_rst_o  out  NUM_STAGES  bit i high = domain i held in reset; registered.
REQ-010 all_ready  out  1  sequence completed with every stage acknowledged; registered.
REQ-011 busy  out  1  sequence in progress (HOLD or WAIT); registered.
REQ-012 timeout_err  out  1  sticky: a stage failed to ack within TIMEOUT; registered.
REQ-013 fail_stage  out  IDX_W  index of the stage that timed out; valid while timeout_err=1.

Function
REQ-014 The FSM SHALL have the states HOLD, WAIT, DONE and ERROR, with an internal cycle counter (8 bit) and stage index idx.
REQ-015 HOLD: the counter SHALL increment each cycle; on the edge where the counter equals DELAY-1, stage_rst_o[idx] SHALL clear, the counter SHALL return to 0, and the state SHALL become WAIT.
REQ-016 WAIT: only stage_ack[idx] SHALL be sampled; acks of unreleased stages and of already-accepted stages SHALL be ignored.
REQ-017 WAIT with stage_ack[idx]=1 and idx<NUM_STAGES-1: idx SHALL increment, the counter SHALL return to 0, and the state SHALL become HOLD.
REQ-018 WAIT with stage_ack[idx]=1 and idx=NUM_STAGES-1: the state SHALL become DONE, with all_ready=1 and busy=0 on the same edge.
REQ-019 WAIT with the ack low and counter=TIMEOUT-1: the state SHALL become ERROR, timeout_err=1, fail_stage=idx, busy=0, and stage_rst_o[idx] re-asserted; stages below idx SHALL stay released.
REQ-020 WAIT with the ack low and counter<TIMEOUT-1: the counter SHALL increment.
REQ-021 An ack already high at release SHALL be accepted after exactly one cycle in WAIT (minimum WAIT dwell is 1 cycle).
REQ-022 DONE: outputs SHALL hold; all_ready SHALL be registered as the AND of stage_ack, so a dropped ack deasserts all_ready one cycle later without re-sequencing.
REQ-023 ERROR: the state SHALL hold until rst_i or sw_rst_req.
REQ-024 sw_rst_req=1 in any state SHALL cause, on the next edge: state HOLD, idx 0, counter 0, stage_rst_o all ones, all_ready 0, busy 1, timeout_err 0, fail_stage 0.
REQ-025 Priority SHALL be rst_i > sw_rst_req > normal FSM operation; the effect of rst_i and sw_rst_req asserted together is identical to rst_i alone.
REQ-026 At most one stage_rst_o bit SHALL change per cycle, and resets SHALL be released strictly in index order 0..NUM_STAGES-1.

Reset
REQ-027 While rst_i=1 at a clock edge: state HOLD, idx 0, counter 0, stage_rst_o all ones, all_ready 0, busy 1, timeout_err 0, fail_stage 0.
REQ-028 rst_i asserted mid-sequence, in DONE or in ERROR SHALL abort immediately to the REQ-027 values; the sequence restarts from stage 0 after rst_i deasserts.

Verification (defaults NUM_STAGES=3, DELAY=4, TIMEOUT=16; edge 1 = first edge with rst_i=0)
REQ-029 rst_i high for 2 cycles, then low, acks tied high -> stage_rst_o=111 through edge 3, 110 at edge 4, 100 at edge 9, 000 at edge 14; all_ready=1 and busy=0 at edge 15.
REQ-030 As REQ-029 but stage_ack[1] held low -> stage 1 released at edge 9; at edge 25 stage_rst_o=110, timeout_err=1, fail_stage=1, busy=0; state holds indefinitely.
REQ-031 From ERROR, pulse sw_rst_req for one cycle with all acks high -> next edge stage_rst_o=111, timeout_err=0, busy=1; full REQ-029 timing repeats from that edge.
REQ-032 In DONE, drop stage_ack[2] -> all_ready=0 one edge later, stage_rst_o stays 000, busy stays 0.
REQ-033 Assert rst_i at edge 10 during WAIT of stage 1 -> at that edge stage_rst_o=111, all_ready=0, busy=1; acks raised early on stages 1 and 2 are not accepted before their stages are released.
REQ-034 sw_rst_req and rst_i high on the same edge during HOLD -> identical to rst_i alone; no glitch or extra release on any stage_rst_o bit.
